wb_port_arbiter: RTL and testbench

// - Shares the single register-file write port among NUM_REQ write-back sources (ALU result, DM load return, multi-cycle MDU result).
// - Sits between the per-source result registers and the write-back register / register file.
// - Uses round-robin arbitration with a valid/ready handshake per source.
// - Produces one registered write per cycle and suppresses writes to register 0.

---
 rtl/wb_port_arbiter.sv | 107 ++++++++++
 tb/tb_wb_port_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ write-back sources.
// Optional macro WB_BYPASS_EN adds a combinational byp_* copy of the handshake-cycle write.
module wb_port_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ADDR_W  = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        wb_hold,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        rf_we,
   output logic [ADDR_W-1:0]           rf_waddr,
   output logic [DATA_W-1:0]           rf_wdata,
   output logic [15:0]                 conflict_cnt
`ifdef WB_BYPASS_EN
   ,
   output logic                        byp_valid,
   output logic [ADDR_W-1:0]           byp_addr,
   output logic [DATA_W-1:0]           byp_data
`endif
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned IDX_W = PTR_W + 1;
   localparam int unsigned POP_W = $clog2(NUM_REQ + 1);

   logic [PTR_W-1:0]  r_ptr;
   logic [PTR_W-1:0]  w_win;
   logic [PTR_W-1:0]  w_ptr_nxt;
   logic [IDX_W-1:0]  w_idx;
   logic              w_found;
   logic              w_xfer;
   logic              w_we;
   logic              w_conflict;
   logic [POP_W-1:0]  w_pop;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;

   // First valid source at or after the pointer, wrapping modulo NUM_REQ
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_idx = IDX_W'(r_ptr) + IDX_W'(k);
         if (w_idx >= IDX_W'(NUM_REQ)) begin
            w_idx = w_idx - IDX_W'(NUM_REQ);
         end
         if (!w_found && req_valid[PTR_W'(w_idx)]) begin
            w_found = 1'b1;
            w_win   = PTR_W'(w_idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      w_xfer    = reset & ~wb_hold & w_found;
      if (w_xfer) begin
         req_ready[w_win] = 1'b1;
      end
      w_addr    = req_addr[32'(w_win) * ADDR_W +: ADDR_W];
      w_data    = req_data[32'(w_win) * DATA_W +: DATA_W];
      w_we      = w_xfer & (w_addr != '0);
      w_ptr_nxt = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
   end

   always_comb begin
      w_pop = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_pop = w_pop + POP_W'(req_valid[i]);
      end
      w_conflict = (w_pop >= POP_W'(2));
   end

   // Register-0 writes are consumed but never reach the register file
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ptr        <= '0;
         rf_we        <= 1'b0;
         rf_waddr     <= '0;
         rf_wdata     <= '0;
         conflict_cnt <= '0;
      end else begin
         rf_we <= w_we;
         if (w_xfer) begin
            r_ptr    <= w_ptr_nxt;
            rf_waddr <= w_addr;
            rf_wdata <= w_data;
         end
         if (w_conflict && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
         end
      end
   end

`ifdef WB_BYPASS_EN
   assign byp_valid = w_we;
   assign byp_addr  = w_addr;
   assign byp_data  = w_data;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed scenarios followed by random traffic,
// checked against a round-robin reference model. Byp_* checks compile in with WB_BYPASS_EN.
module tb_wb_port_arbiter;

   localparam int unsigned N  = 3;
   localparam int unsigned DW = 16;
   localparam int unsigned AW = 3;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            wb_hold;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            rf_we;
   logic [AW-1:0]   rf_waddr;
   logic [DW-1:0]   rf_wdata;
   logic [15:0]     conflict_cnt;
`ifdef WB_BYPASS_EN
   logic            byp_valid;
   logic [AW-1:0]   byp_addr;
   logic [DW-1:0]   byp_data;
`endif

   int          checks = 0;
   int          errors = 0;
   wr_t         exp_q[$];
   int          m_ptr  = 0;
   int unsigned m_cnt  = 0;
   logic [N-1:0] m_xfer = '0;

   wb_port_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .wb_hold      (wb_hold),
      .req_valid    (req_valid),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .conflict_cnt (conflict_cnt)
`ifdef WB_BYPASS_EN
      ,
      .byp_valid    (byp_valid),
      .byp_addr     (byp_addr),
      .byp_data     (byp_data)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   // Reference model: round-robin search from the pointer, evaluated mid-cycle
   always @(negedge clk) begin
      int           win;
      int           pc;
      logic [N-1:0] exp_rdy;
      wr_t          w;
      win     = -1;
      pc      = 0;
      exp_rdy = '0;
      for (int i = 0; i < N; i++) if (req_valid[i]) pc++;
      for (int k = 0; k < N; k++) begin
         if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      if (reset && !wb_hold && win >= 0) exp_rdy[win] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      m_xfer = exp_rdy;
      w.a = (win >= 0) ? req_addr[win*AW +: AW] : '0;
      w.d = (win >= 0) ? req_data[win*DW +: DW] : '0;
`ifdef WB_BYPASS_EN
      chk("byp_valid", 32'(byp_valid), 32'((exp_rdy != '0) && (w.a != '0)));
      if ((exp_rdy != '0) && (w.a != '0)) begin
         chk("byp_addr", 32'(byp_addr), 32'(w.a));
         chk("byp_data", 32'(byp_data), 32'(w.d));
      end
`endif
      if (!reset) begin
         m_ptr = 0;
         m_cnt = 0;
      end else begin
         if (pc >= 2 && m_cnt < 32'hFFFF) m_cnt++;
         if (exp_rdy != '0) begin
            if (w.a != '0) exp_q.push_back(w);
            m_ptr = (win + 1) % N;
         end
      end
   end

   // Monitor: registered outputs after each edge against the scoreboard
   initial begin
      forever begin
         logic exp_we;
         wr_t  e;
         cyc();
         exp_we = (exp_q.size() != 0);
         chk("rf_we", 32'(rf_we), 32'(exp_we));
         if (exp_we) begin
            e = exp_q.pop_front();
            chk("rf_waddr", 32'(rf_waddr), 32'(e.a));
            chk("rf_wdata", 32'(rf_wdata), 32'(e.d));
         end
         chk("conflict_cnt", 32'(conflict_cnt), m_cnt);
      end
   end

   initial begin
      logic          v[N];
      logic [AW-1:0] a[N];
      logic [DW-1:0] d[N];

      // T1 reset with all sources requesting
      reset = 1'b0; wb_hold = 1'b0; req_valid = 3'b111;
      req_addr = '0; req_data = '0;
      set_src(0, 3'd1, 16'h0101); set_src(1, 3'd2, 16'h0202); set_src(2, 3'd3, 16'h0303);
      cyc(); cyc();
      chk("t1_ready", 32'(req_ready), 32'd0);
      chk("t1_we", 32'(rf_we), 32'd0);
      chk("t1_waddr", 32'(rf_waddr), 32'd0);
      chk("t1_wdata", 32'(rf_wdata), 32'd0);
      chk("t1_cnt", 32'(conflict_cnt), 32'd0);
      reset = 1'b1; req_valid = '0;
      cyc();

      // T2 single source
      req_valid = 3'b010; set_src(1, 3'd5, 16'h1234);
      @(negedge clk); chk("t2_ready", 32'(req_ready), 32'b010);
      cyc();
      chk("t2_we", 32'(rf_we), 32'd1);
      chk("t2_waddr", 32'(rf_waddr), 32'd5);
      chk("t2_wdata", 32'(rf_wdata), 32'h1234);
      req_valid = '0;

      // T3 full contention from a fresh reset
      reset = 1'b0; cyc(); reset = 1'b1;
      set_src(0, 3'd1, 16'hA000); set_src(1, 3'd2, 16'hA001); set_src(2, 3'd3, 16'hA002);
      req_valid = 3'b111;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk); chk("t3_grant", 32'(req_ready), 32'(1 << (j % 3)));
         cyc(); chk("t3_we", 32'(rf_we), 32'd1);
      end
      chk("t3_cnt", 32'(conflict_cnt), 32'd6);
      req_valid = '0;

      // T4 register-0 write is consumed without a register-file write
      req_valid = 3'b100; set_src(2, 3'd0, 16'hBEEF);
      @(negedge clk); chk("t4_ready", 32'(req_ready), 32'b100);
      cyc(); chk("t4_we", 32'(rf_we), 32'd0);
      req_valid = '0;

      // T5 hold suspends grants but still counts conflicts
      set_src(0, 3'd4, 16'h00C0); set_src(1, 3'd6, 16'h00C1);
      req_valid = 3'b011; wb_hold = 1'b1;
      repeat (3) begin
         @(negedge clk); chk("t5_ready", 32'(req_ready), 32'd0);
         cyc(); chk("t5_we", 32'(rf_we), 32'd0);
      end
      chk("t5_cnt", 32'(conflict_cnt), 32'd9);
      wb_hold = 1'b0;
      @(negedge clk); chk("t5_release", 32'(req_ready), 32'b001);
      cyc(); chk("t5_waddr", 32'(rf_waddr), 32'd4);
      req_valid = 3'b010;
      @(negedge clk); chk("t5_next", 32'(req_ready), 32'b010);
      cyc(); req_valid = '0;

      // T6 reset in a would-be transfer cycle, pointer was 2
      reset = 1'b0; req_valid = 3'b011;
      @(negedge clk); chk("t6_ready", 32'(req_ready), 32'd0);
      cyc();
      chk("t6_we", 32'(rf_we), 32'd0);
      chk("t6_waddr", 32'(rf_waddr), 32'd0);
      chk("t6_wdata", 32'(rf_wdata), 32'd0);
      chk("t6_cnt", 32'(conflict_cnt), 32'd0);
      reset = 1'b1;
      @(negedge clk); chk("t6_first", 32'(req_ready), 32'b001);
      cyc(); req_valid = '0;

      // Random traffic: sources hold requests until transferred
      for (int i = 0; i < N; i++) begin
         v[i] = 1'b0; a[i] = '0; d[i] = '0;
      end
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (m_xfer[i]) v[i] = 1'b0;
            if (!v[i] && $urandom_range(0, 2) != 0) begin
               v[i] = 1'b1;
               a[i] = AW'($urandom_range(0, 7));
               d[i] = DW'($urandom);
            end
            req_valid[i] = v[i];
            set_src(i, a[i], d[i]);
         end
         wb_hold = ($urandom_range(0, 9) == 0);
         reset   = ($urandom_range(0, 99) != 0);
         cyc();
      end

      reset = 1'b1; wb_hold = 1'b0; req_valid = '0;
      cyc(); cyc(); cyc();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
